// File: rtl/imem_arb.sv
// imem_arb: two-requester round-robin arbiter for a shared instruction-memory port.
//
// Requester 0 (prefetcher) and requester 1 (secondary fetch master) compete for
// one memory request port. The arbiter accepts at most one request per cycle
// and records the owner of each accepted read in an in-order ID FIFO. It uses
// that FIFO to route each in-order response back to its owner.
// A per-requester kill marks that requester's in-flight reads so their
// responses are swallowed.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   sN_req/sN_addr/sN_kill      requester N request, address, flush pulse
//   sN_busy                     request not accepted this cycle (hold req/addr)
//   sN_rvalid/sN_rdata/sN_bad   response strobe for N; data/fault are broadcast
//   m_req/m_addr/m_busy         memory request side
//   m_rvalid/m_rdata/m_bad      memory in-order response side
//   err                         sticky: response seen with nothing outstanding
module imem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_req,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic              s0_kill,
    output logic              s0_busy,
    output logic              s0_rvalid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_bad,
    input  logic              s1_req,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic              s1_kill,
    output logic              s1_busy,
    output logic              s1_rvalid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_bad,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_busy,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_bad,
    output logic              err
);

    localparam int PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTS + 1);

    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                last_grant_reg;
    logic                err_reg;

    // Per-entry owner id and kill mark, gathered into vectors for head lookup.
    logic [MAX_OUTS-1:0] entry_id;
    logic [MAX_OUTS-1:0] entry_kill;

    logic                grant;
    logic                can_acc;
    logic                accept;
    logic                pop;
    logic                head_id;
    logic                head_kill;
    logic                not_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_empty = (count_reg != '0);
    assign head_id   = entry_id[rd_ptr_reg];
    assign head_kill = entry_kill[rd_ptr_reg];

    // A response returning this cycle frees its slot for a same-cycle accept.
    assign can_acc = (count_reg < CNT_W'(MAX_OUTS)) | (m_rvalid & not_empty);

    // Tie goes to whichever requester did not win the last accepted request.
    always_comb begin
        grant = s1_req;
        if (s0_req && s1_req) begin
            grant = ~last_grant_reg;
        end
    end

    assign m_req  = (s0_req | s1_req) & can_acc & ~rst;
    assign m_addr = grant ? s1_addr : s0_addr;
    assign accept = m_req & ~m_busy;
    assign pop    = m_rvalid & not_empty & ~rst;

    assign s0_busy = s0_req & ~(accept & ~grant);
    assign s1_busy = s1_req & ~(accept & grant);

    // A kill in the same cycle as the head response suppresses it directly,
    // since the mark set on the entry would only take effect after the edge.
    assign s0_rvalid = pop & ~head_id & ~head_kill & ~s0_kill;
    assign s1_rvalid = pop &  head_id & ~head_kill & ~s1_kill;
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_bad    = m_bad;
    assign s1_bad    = m_bad;
    assign err       = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTS; gi++) begin : g_entry
            logic id_reg;
            logic kill_reg;

            // A push overrides a kill on the same slot: the newly accepted
            // read was not outstanding before the edge, so it stays live.
            // Marking stale (empty) slots is harmless; a push clears them.
            always_ff @(posedge clk) begin
                if (rst) begin
                    id_reg   <= 1'b0;
                    kill_reg <= 1'b0;
                end else if (accept && (wr_ptr_reg == PTR_W'(gi))) begin
                    id_reg   <= grant;
                    kill_reg <= 1'b0;
                end else if ((s0_kill && !id_reg) || (s1_kill && id_reg)) begin
                    kill_reg <= 1'b1;
                end
            end

            assign entry_id[gi]   = id_reg;
            assign entry_kill[gi] = kill_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            last_grant_reg <= 1'b1;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg     <= ptr_inc(wr_ptr_reg);
                last_grant_reg <= grant;
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (accept && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !accept) begin
                count_reg <= count_reg - 1'b1;
            end
            if (m_rvalid && !not_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: self-checking bench for imem_arb.
// Phase 1 walks a table of directed cycles (scenarios from reset through
// grant alternation, capacity, kill, memory stall and error). Phase 2 drives
// random traffic and compares against a queue-based reference model.
module tb_imem_arb;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_OUTS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_req, s0_kill, s1_req, s1_kill;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic              s0_busy, s0_rvalid, s1_busy, s1_rvalid;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic [1:0]        s0_bad, s1_bad;
    logic              m_req, m_busy, m_rvalid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_bad;
    logic              err;

    always #5 clk = ~clk;

    imem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_kill(s0_kill), .s0_busy(s0_busy),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_bad(s0_bad),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_kill(s1_kill), .s1_busy(s1_busy),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_bad(s1_bad),
        .m_req(m_req), .m_addr(m_addr), .m_busy(m_busy),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_bad(m_bad), .err(err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a queue of outstanding reads (owner, killed flag),
    // plus who won the last accepted request and the sticky error.
    int q_own[$];
    bit q_kill[$];
    int last_win = 1;
    bit mdl_err  = 0;

    bit e_mreq, e_b0, e_b1, e_v0, e_v1, e_acc;
    int e_grant;

    task automatic model_predict();
        int n;
        bit room;
        n = q_own.size();
        room = (n < MAX_OUTS) || (m_rvalid && n > 0);
        if (s0_req && s1_req) e_grant = (last_win == 0) ? 1 : 0;
        else                  e_grant = s1_req ? 1 : 0;
        e_mreq = !rst && (s0_req || s1_req) && room;
        e_acc  = e_mreq && !m_busy;
        e_b0   = s0_req && !(e_acc && e_grant == 0);
        e_b1   = s1_req && !(e_acc && e_grant == 1);
        e_v0 = 0;
        e_v1 = 0;
        if (!rst && m_rvalid && n > 0 && !q_kill[0]) begin
            e_v0 = (q_own[0] == 0) && !s0_kill;
            e_v1 = (q_own[0] == 1) && !s1_kill;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            q_own.delete();
            q_kill.delete();
            last_win = 1;
            mdl_err  = 0;
        end else begin
            for (int i = 0; i < q_own.size(); i++) begin
                if ((q_own[i] == 0 && s0_kill) || (q_own[i] == 1 && s1_kill)) q_kill[i] = 1;
            end
            if (m_rvalid && q_own.size() == 0) mdl_err = 1;
            if (m_rvalid && q_own.size() > 0) begin
                void'(q_own.pop_front());
                void'(q_kill.pop_front());
            end
            if (e_acc) begin
                q_own.push_back(e_grant);
                q_kill.push_back(0);
                last_win = e_grant;
            end
        end
    endtask

    typedef struct {
        logic rst, r0, r1, k0, k1, mb, mv;
        logic mreq, b0, b1, v0, v1, er;
        int   asel;   // 0: expect s0_addr, 1: expect s1_addr, 2: don't care
    } vec_t;

    vec_t tbl[27];

    initial begin
        int  hold0, hold1;
        rst = 1; s0_req = 0; s1_req = 0; s0_kill = 0; s1_kill = 0;
        s0_addr = 32'h0000_1000; s1_addr = 32'h8000_0100;
        m_busy = 0; m_rvalid = 0; m_rdata = 32'h0000_0013; m_bad = 2'b00;

        //              rst r0 r1 k0 k1 mb mv   mreq b0 b1 v0 v1 er asel
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 2}; // reset, rvalid ignored
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0}; // s0 alone accepted
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2}; // s0 response
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1}; // tie -> s1
        tbl[4]  = '{0, 1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0, 0}; // tie -> s0, resp s1
        tbl[5]  = '{0, 1, 1, 0, 0, 0, 1,   1, 1, 0, 1, 0, 0, 1}; // tie -> s1, resp s0
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 2}; // resp s1
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0}; // fill 1
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1}; // fill 2
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 2}; // full: blocked
        tbl[10] = '{0, 1, 1, 0, 0, 0, 1,   1, 0, 1, 1, 0, 0, 0}; // pop+push
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0}; // s0 out 1
        tbl[14] = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0}; // s0 out 2
        tbl[15] = '{0, 1, 0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0}; // kill+resp+accept
        tbl[16] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 2}; // killed entry
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0, 2}; // post-kill entry live
        tbl[18] = '{0, 0, 1, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0, 1}; // m_busy stall 1
        tbl[19] = '{0, 0, 1, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0, 1}; // stall 2
        tbl[20] = '{0, 0, 1, 0, 0, 1, 0,   1, 0, 1, 0, 0, 0, 1}; // stall 3
        tbl[21] = '{0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1}; // accepted
        tbl[22] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2}; // reset with 1 outstanding
        tbl[23] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 2}; // orphan response
        tbl[24] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 2}; // err sticky
        tbl[25] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 2};
        tbl[26] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2}; // err cleared

        @(negedge clk);
        for (int i = 0; i < 27; i++) begin
            rst = tbl[i].rst; s0_req = tbl[i].r0; s1_req = tbl[i].r1;
            s0_kill = tbl[i].k0; s1_kill = tbl[i].k1;
            m_busy = tbl[i].mb; m_rvalid = tbl[i].mv;
            #1;
            model_predict();
            chk($sformatf("row%0d m_req", i), 32'(m_req), 32'(tbl[i].mreq));
            chk($sformatf("row%0d s0_busy", i), 32'(s0_busy), 32'(tbl[i].b0));
            chk($sformatf("row%0d s1_busy", i), 32'(s1_busy), 32'(tbl[i].b1));
            chk($sformatf("row%0d s0_rvalid", i), 32'(s0_rvalid), 32'(tbl[i].v0));
            chk($sformatf("row%0d s1_rvalid", i), 32'(s1_rvalid), 32'(tbl[i].v1));
            chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].er));
            if (tbl[i].asel == 0) chk($sformatf("row%0d m_addr", i), m_addr, 32'h0000_1000);
            if (tbl[i].asel == 1) chk($sformatf("row%0d m_addr", i), m_addr, 32'h8000_0100);
            if (tbl[i].v0 == 1'b1) chk($sformatf("row%0d s0_rdata", i), s0_rdata, 32'h0000_0013);
            $display("row %0d: m_req=%0b busy=%0b%0b rvalid=%0b%0b err=%0b m_addr=%08h",
                     i, m_req, s0_busy, s1_busy, s0_rvalid, s1_rvalid, err, m_addr);
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        // Random traffic against the reference model. Requesters that saw
        // busy keep req/addr stable until accepted.
        hold0 = 0; hold1 = 0;
        rst = 1; s0_req = 0; s1_req = 0; s0_kill = 0; s1_kill = 0; m_rvalid = 0;
        #1; model_predict();
        @(posedge clk); model_update(); @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!hold0) begin
                s0_req = ($urandom_range(0, 2) != 0);
                s0_addr = $urandom();
            end
            if (!hold1) begin
                s1_req = ($urandom_range(0, 2) != 0);
                s1_addr = $urandom();
            end
            s0_kill = ($urandom_range(0, 9) == 0);
            s1_kill = ($urandom_range(0, 9) == 0);
            m_busy  = ($urandom_range(0, 3) == 0);
            if (q_own.size() > 0) m_rvalid = ($urandom_range(0, 2) != 0);
            else                  m_rvalid = ($urandom_range(0, 40) == 0);
            m_rdata = $urandom();
            m_bad   = 2'($urandom_range(0, 3));
            #1;
            model_predict();
            chk("rnd m_req", 32'(m_req), 32'(e_mreq));
            chk("rnd s0_busy", 32'(s0_busy), 32'(e_b0));
            chk("rnd s1_busy", 32'(s1_busy), 32'(e_b1));
            chk("rnd s0_rvalid", 32'(s0_rvalid), 32'(e_v0));
            chk("rnd s1_rvalid", 32'(s1_rvalid), 32'(e_v1));
            chk("rnd err", 32'(err), 32'(mdl_err));
            if (e_mreq) chk("rnd m_addr", m_addr, (e_grant == 1) ? s1_addr : s0_addr);
            if (e_v1)   chk("rnd s1_bad", 32'(s1_bad), 32'(m_bad));
            if (c % 100 == 0)
                $display("rnd %0d: m_req=%0b busy=%0b%0b rvalid=%0b%0b err=%0b outstanding=%0d",
                         c, m_req, s0_busy, s1_busy, s0_rvalid, s1_rvalid, err, q_own.size());
            hold0 = (!rst && e_b0) ? 1 : 0;
            hold1 = (!rst && e_b1) ? 1 : 0;
            @(posedge clk);
            model_update();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
Name: imem_arb

Overview:
Two-requester arbiter that shares the single instruction-memory port between the fetch unit's prefetcher (requester 0) and a second instruction-side master (requester 1, e.g. debug/page-walk fetch).
- Performs round-robin grant with one-accept-per-cycle.
- Tracks up to MAX_OUTS in-order outstanding reads in an ID FIFO and routes each response back to its owner.
- Supports per-requester kill (flush) of in-flight responses so redirected fetches never see stale data.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, read data width
MAX_OUTS, 2, maximum outstanding accepted reads (ID FIFO depth, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s0_req  in  1  requester 0 read request
s0_addr  in  ADDR_W  requester 0 address
s0_kill  in  1  drop all requester-0 responses outstanding before this edge
s0_busy  out  1  request not accepted this cycle
s0_rvalid  out  1  response for requester 0
s0_rdata  out  DATA_W  response data (broadcast of m_rdata)
s0_bad  out  2  response fault {xes, page} (broadcast of m_bad)
s1_req, s1_addr, s1_kill, s1_busy, s1_rvalid, s1_rdata, s1_bad  same as requester 0
m_req  out  1  memory request
m_addr  out  ADDR_W  memory address
m_busy  in  1  memory cannot accept this cycle
m_rvalid  in  1  in-order response strobe
m_rdata  in  DATA_W  response data
m_bad  in  2  response fault bits
err  out  1  sticky: m_rvalid with no outstanding entry

Behaviour:
- Reset (rst=1 at edge): FIFO count/rd/wr pointers=0, last-grant=1 (s0 wins first tie), err=0, all kill marks cleared. While rst=1: m_req=0, sNrvalid=0, sN_busy=sN_req. m_rvalid during reset is discarded without setting err.
- Capacity:
  - can_acc = (count<MAX_OUTS) | (m_rvalid & count!=0), i.e. a same-cycle pop frees a slot.
  - m_req = (s0_req|s1_req) & can_acc.
- Grant (combinational):
  - Only one requester active: it is granted.
  - Both active: grant the one not equal to last-grant.
  - m_addr = granted requester's addr.
- Accept = m_req & ~m_busy.
  - On accept: push {id=grant, kill=0} at wr pointer, last-grant<=grant.
  - last-grant updates only on accept, never on stall.
- sN_busy = sN_req & ~(accept & grant==N). The loser, a stalled winner and a capacity-blocked requester all see busy=1 and must hold req/addr stable.
- Response: on m_rvalid & count!=0, pop head.
  - sN_rvalid = m_rvalid & head.id==N & ~head.kill & ~sN_kill.
  - rdata/bad are passed through combinationally, with zero added latency.
- Kill: sN_kill sets kill on every FIFO entry with id==N held before the edge.
  - An entry pushed in the same cycle as sN_kill is not killed.
  - A head response for N in the same cycle as sN_kill is suppressed.
  - Kill does not affect m_req/acceptance in that cycle.
- Count: count_next = count + push - pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo MAX_OUTS.
- m_rvalid with count==0: ignored (no pop, no rvalid), err<=1. err clears only on rst.
- A killed entry still occupies a slot until its response returns.

Test Plan:
1. s0 alone, m_busy=0, memory returns 1 cycle later with rdata=0x00000013, bad=0 -> s0_busy=0 at accept, s0_rvalid=1 with 0x13 next cycle, s1_rvalid=0.
2. s0,s1 both request continuously after reset, MAX_OUTS=2, 1-cycle response -> grants alternate s0,s1,s0,s1 and responses are routed in the same order.
3. MAX_OUTS=2, memory withholds responses -> two accepts, then m_req=0 and both busy=1. Response arrives -> the same cycle accepts the third request (pop+push), count stays 2.
4. s0 has 2 outstanding; pulse s0_kill while a new s0 request is accepted -> first two responses give s0_rvalid=0, third gives s0_rvalid=1.
5. m_busy=1 for 3 cycles with s1 requesting, addr 0x80000100 -> m_addr stable, s1_busy=1, last-grant unchanged, accept on 4th cycle.
6. rst asserted with 1 outstanding, then m_rvalid after release -> no sNrvalid, err=1; second rst clears err=0.
